pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_md_sequencer.sv | 67 ++++++
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU header: pipeline-control FSM encodings and HI/LO unit latencies.
package pipeline_ctrl_pkg;

  localparam int unsigned DefaultDivCycles = 32;
  localparam int unsigned DefaultMulCycles = 2;

  // Mul/div sequencer states
  typedef enum logic [1:0] {
    MdIdle,
    MdBusy,
    MdDone
  } md_state_e;

  // Fetch flush states; Drop discards the stale in-flight fetch after an exception
  typedef enum logic {
    FlRun,
    FlDrop
  } fl_state_e;

  // Non-zero destination that feeds either decode source operand
  function automatic logic reg_match(logic [4:0] dst, logic [4:0] src1, logic [4:0] src2);
    return (dst != 5'd0) && ((dst == src1) || (dst == src2));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_md_sequencer.sv
// HI/LO unit occupancy sequencer: tracks how long a mul/div keeps the unit busy.
module md_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DefaultDivCycles,
  parameter int unsigned MUL_CYCLES = DefaultMulCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_flush,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);

  md_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic            r_done;

  // Occupancy FSM with registered busy/done; a flush abandons the operation silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MdIdle;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        // Done behaves like Idle for a back-to-back start
        MdIdle, MdDone: begin
          if (i_start && !i_flush) begin
            r_state <= MdBusy;
            r_cnt   <= i_is_div ? DivLoad : MulLoad;
            r_busy  <= 1'b1;
          end else begin
            r_state <= MdIdle;
          end
        end
        // Start is held by the stalled execute stage here, so it is not a new request
        MdBusy: begin
          if (i_flush) begin
            r_state <= MdIdle;
          end else if (r_cnt == '0) begin
            r_state <= MdDone;
            r_done  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_busy <= 1'b1;
          end
        end
        default: r_state <= MdIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: prioritised stall/bubble generation, HI/LO occupancy
// and stale-fetch dropping after an exception flush.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DefaultDivCycles,
  parameter int unsigned MUL_CYCLES = DefaultMulCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_src1,
  input  logic [4:0] d_src2,
  input  logic       d_isJumpInstr,
  input  logic [4:0] e_dst,
  input  logic [4:0] m_dst,
  input  logic       e_isLoad,
  input  logic       m_isLoad,
  input  logic       md_start,
  input  logic       md_isDiv,
  input  logic       i_req,
  input  logic       i_data_ok,
  input  logic       m_req,
  input  logic       m_data_ok,
  input  logic       m_excValid,
  output logic       F_stall,
  output logic       D_stall,
  output logic       E_stall,
  output logic       M_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_bubble,
  output logic       md_busy,
  output logic       md_done,
  output logic       fetch_drop
);

  fl_state_e r_fl_state;
  logic      w_md_busy;
  logic      w_dmem_wait;
  logic      w_fetch_wait;
  logic      w_load_use;
  logic      w_branch_load;

  md_sequencer #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_md_sequencer (
    .clk     (clk),
    .reset   (reset),
    .i_start (md_start),
    .i_is_div(md_isDiv),
    .i_flush (m_excValid),
    .o_busy  (w_md_busy),
    .o_done  (md_done)
  );

  assign md_busy = w_md_busy;

  assign w_dmem_wait   = m_req & ~m_data_ok;
  assign w_fetch_wait  = i_req & ~i_data_ok;
  assign w_load_use    = e_isLoad & reg_match(e_dst, d_src1, d_src2);
  assign w_branch_load = d_isJumpInstr & m_isLoad & reg_match(m_dst, d_src1, d_src2);

  // Flush FSM: after an exception with a fetch still in flight, drop its response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fl_state <= FlRun;
    end else begin
      case (r_fl_state)
        FlRun:   if (m_excValid && i_req && !i_data_ok) r_fl_state <= FlDrop;
        FlDrop:  if (i_data_ok) r_fl_state <= FlRun;
        default: r_fl_state <= FlRun;
      endcase
    end
  end

  // A response arriving in the exception cycle itself is already stale
  assign fetch_drop = ~reset & ((r_fl_state == FlDrop) | (m_excValid & i_data_ok));

  // Hazard priority: only the highest active hazard shapes the stall/bubble set
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    if (reset) begin
      // all held low while in reset
    end else if (m_excValid) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (w_dmem_wait) begin
      // Also covers a busy HI/LO unit: M stall beats M bubble, counter keeps running
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = 1'b1;
    end else if (w_md_busy) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_bubble = 1'b1;
    end else if (r_fl_state == FlDrop) begin
      // Fetch keeps moving so the stale response can be consumed and discarded
      D_bubble = 1'b1;
    end else if (w_fetch_wait) begin
      F_stall  = 1'b1;
      D_bubble = 1'b1;
    end else if (w_load_use || w_branch_load) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level reference model of the hazard rules.
module tb_pipeline_ctrl;

  localparam int unsigned DivCycles = 32;
  localparam int unsigned MulCycles = 2;

  typedef struct packed {
    logic       rst;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       jump;
    logic [4:0] e_dst;
    logic [4:0] m_dst;
    logic       e_load;
    logic       m_load;
    logic       start;
    logic       is_div;
    logic       i_req;
    logic       i_ok;
    logic       m_req;
    logic       m_ok;
    logic       exc;
  } stim_t;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic m_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_bubble;
    logic busy;
    logic done;
    logic drop;
  } out_t;

  typedef struct packed {
    int unsigned cyc;
    int unsigned tag;
    out_t        exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] d_src1 = '0, d_src2 = '0, e_dst = '0, m_dst = '0;
  logic       d_isJumpInstr = 0, e_isLoad = 0, m_isLoad = 0, md_start = 0, md_isDiv = 0;
  logic       i_req = 0, i_data_ok = 0, m_req = 0, m_data_ok = 0, m_excValid = 0;
  logic       F_stall, D_stall, E_stall, M_stall;
  logic       D_bubble, E_bubble, M_bubble, W_bubble;
  logic       md_busy, md_done, fetch_drop;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .DIV_CYCLES(DivCycles),
    .MUL_CYCLES(MulCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_src1       (d_src1),
    .d_src2       (d_src2),
    .d_isJumpInstr(d_isJumpInstr),
    .e_dst        (e_dst),
    .m_dst        (m_dst),
    .e_isLoad     (e_isLoad),
    .m_isLoad     (m_isLoad),
    .md_start     (md_start),
    .md_isDiv     (md_isDiv),
    .i_req        (i_req),
    .i_data_ok    (i_data_ok),
    .m_req        (m_req),
    .m_data_ok    (m_data_ok),
    .m_excValid   (m_excValid),
    .F_stall      (F_stall),
    .D_stall      (D_stall),
    .E_stall      (E_stall),
    .M_stall      (M_stall),
    .D_bubble     (D_bubble),
    .E_bubble     (E_bubble),
    .M_bubble     (M_bubble),
    .W_bubble     (W_bubble),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .fetch_drop   (fetch_drop)
  );

  // Reference model state: cycles of HI/LO occupancy left, pending done, dropping fetch
  int   md_left = 0;
  bit   md_done_now = 0;
  bit   dropping = 0;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  function automatic bit feeds(logic [4:0] dst, logic [4:0] a, logic [4:0] b);
    return (dst != 0) && (dst == a || dst == b);
  endfunction

  function out_t model_out(stim_t s);
    out_t o;
    bit   lu;
    o = '0;
    if (s.rst) return o;
    o.busy = (md_left > 0);
    o.done = md_done_now;
    o.drop = dropping || (s.exc && s.i_ok);
    lu = (s.e_load && feeds(s.e_dst, s.src1, s.src2)) ||
         (s.jump && s.m_load && feeds(s.m_dst, s.src1, s.src2));
    if (s.exc) begin
      o.d_bubble = 1; o.e_bubble = 1; o.m_bubble = 1;
    end else if (s.m_req && !s.m_ok) begin
      o.f_stall = 1; o.d_stall = 1; o.e_stall = 1; o.m_stall = 1; o.w_bubble = 1;
    end else if (md_left > 0) begin
      o.f_stall = 1; o.d_stall = 1; o.e_stall = 1; o.m_bubble = 1;
    end else if (dropping) begin
      o.d_bubble = 1;
    end else if (s.i_req && !s.i_ok) begin
      o.f_stall = 1; o.d_bubble = 1;
    end else if (lu) begin
      o.f_stall = 1; o.d_stall = 1; o.e_bubble = 1;
    end
    return o;
  endfunction

  function void model_advance(stim_t s);
    if (s.rst) begin
      md_left = 0; md_done_now = 0; dropping = 0;
      return;
    end
    if (s.exc) begin
      md_left = 0; md_done_now = 0;
    end else if (md_left > 0) begin
      md_left--;
      md_done_now = (md_left == 0);
    end else begin
      md_done_now = 0;
      if (s.start) md_left = s.is_div ? DivCycles : MulCycles;
    end
    if (s.i_ok) dropping = 0;
    else if (s.exc && s.i_req) dropping = 1;
  endfunction

  function automatic stim_t idle();
    return '0;
  endfunction

  // Apply one cycle of stimulus shortly after the clock edge and queue its expectation
  task automatic drive(input stim_t s, input int unsigned tag);
    sb_t e;
    @(posedge clk);
    #1;
    reset = s.rst; d_src1 = s.src1; d_src2 = s.src2; d_isJumpInstr = s.jump;
    e_dst = s.e_dst; m_dst = s.m_dst; e_isLoad = s.e_load; m_isLoad = s.m_load;
    md_start = s.start; md_isDiv = s.is_div; i_req = s.i_req; i_data_ok = s.i_ok;
    m_req = s.m_req; m_data_ok = s.m_ok; m_excValid = s.exc;
    e.cyc = cyc; e.tag = tag; e.exp = model_out(s);
    sb_q.push_back(e);
    model_advance(s);
    cyc++;
  endtask

  task automatic idle_n(input int n, input int unsigned tag);
    for (int i = 0; i < n; i++) drive(idle(), tag);
  endtask

  // Monitor: every mid-cycle sample is matched against the oldest queued expectation
  always @(negedge clk) begin
    sb_t  e;
    out_t act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble,
             md_busy, md_done, fetch_drop};
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL outputs scenario %0d cycle %0d: got %b required %b (FDEM stall, DEMW bubble, busy done drop)",
                 e.tag, e.cyc, act, e.exp);
      end
    end
  end

  initial begin
    stim_t s;

    // 1: reset state
    s = idle(); s.rst = 1;
    drive(s, 1); drive(s, 1);
    idle_n(2, 1);

    // 2: load-use one cycle, then a zero destination that must not stall
    s = idle(); s.e_load = 1; s.e_dst = 5; s.src1 = 5;
    drive(s, 2);
    idle_n(1, 2);
    s.e_dst = 0; s.src1 = 0;
    drive(s, 2);
    s = idle(); s.jump = 1; s.m_load = 1; s.m_dst = 7; s.src2 = 7;
    drive(s, 2);
    idle_n(1, 2);

    // 3: divide occupancy with start held while busy, then a multiply
    s = idle(); s.start = 1; s.is_div = 1;
    for (int i = 0; i < 33; i++) drive(s, 3);
    idle_n(3, 3);
    s.is_div = 0;
    drive(s, 3);
    idle_n(4, 3);

    // 4: exception at busy cycle 10 aborts the divide
    s = idle(); s.start = 1; s.is_div = 1;
    drive(s, 4);
    idle_n(9, 4);
    s = idle(); s.exc = 1;
    drive(s, 4);
    idle_n(36, 4);

    // 5: exception with fetch outstanding, response three cycles later
    s = idle(); s.i_req = 1; s.exc = 1;
    drive(s, 5);
    s.exc = 0;
    drive(s, 5); drive(s, 5);
    s.i_ok = 1;
    drive(s, 5);
    idle_n(2, 5);
    s = idle(); s.i_req = 1; s.i_ok = 1; s.exc = 1;
    drive(s, 5);
    idle_n(2, 5);

    // 6: data-memory wait coinciding with load-use
    s = idle(); s.m_req = 1; s.e_load = 1; s.e_dst = 9; s.src2 = 9;
    drive(s, 6);
    s.m_ok = 1;
    drive(s, 6);
    idle_n(1, 6);

    // 7: reset mid-busy, fresh count afterwards; reset mid-drop
    s = idle(); s.start = 1; s.is_div = 1;
    drive(s, 7);
    idle_n(5, 7);
    s = idle(); s.rst = 1;
    drive(s, 7);
    s = idle(); s.start = 1;
    drive(s, 7);
    idle_n(4, 7);
    s = idle(); s.i_req = 1; s.exc = 1;
    drive(s, 7);
    s = idle(); s.rst = 1; s.i_req = 1;
    drive(s, 7);
    s.rst = 0;
    drive(s, 7);
    idle_n(1, 7);

    // 8: random traffic
    for (int i = 0; i < 2500; i++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 499) == 0);
      s.src1   = 5'($urandom_range(0, 3));
      s.src2   = 5'($urandom_range(0, 3));
      s.jump   = ($urandom_range(0, 2) == 0);
      s.e_dst  = 5'($urandom_range(0, 3));
      s.m_dst  = 5'($urandom_range(0, 3));
      s.e_load = ($urandom_range(0, 1) == 0);
      s.m_load = ($urandom_range(0, 1) == 0);
      s.start  = ($urandom_range(0, 7) == 0);
      s.is_div = ($urandom_range(0, 3) == 0);
      s.i_req  = ($urandom_range(0, 4) < 3);
      s.i_ok   = ($urandom_range(0, 1) == 0);
      s.m_req  = ($urandom_range(0, 2) == 0);
      s.m_ok   = ($urandom_range(0, 4) < 3);
      s.exc    = ($urandom_range(0, 39) == 0);
      drive(s, 8);
    end
    idle_n(2, 8);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
